alu_debug_console: RTL

Parametrised, sequential successor to the board-level ALU harness. Replaces raw switch/key wiring with debounced key events and an operand-entry state machine. Operands wider than the switch bank are shifted in as chunks. Results and flags are captured into registers, with sticky flags and a selectable display source. Sits between the board I/O (keys, switches, LEDs, 7-seg) and one alu instance connected through alu_if.

---
 rtl/alu_debug_console_pkg.sv | 48 ++++
 rtl/alu_debug_console_if.sv | 11 +
 rtl/alu_debug_console_key_debounce.sv | 61 ++++++
 rtl/alu_debug_console.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/alu_debug_console_pkg.sv
// Shared types, constants and the 7-segment glyph table for the ALU debug console.
package alu_console_pkg;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    EXEC   = 2'd2,
    SHOW   = 2'd3
  } console_state_t;

  typedef enum logic [1:0] {
    VIEW_RES = 2'd0,
    VIEW_A   = 2'd1,
    VIEW_B   = 2'd2
  } view_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam int KEY_LOAD  = 0;
  localparam int KEY_NEXT  = 1;
  localparam int KEY_VIEW  = 2;
  localparam int KEY_CLEAR = 3;

  // Active-low segments, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/alu_debug_console_if.sv
// Operand/opcode/result bus between the console and one ALU instance.
interface alu_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       ops;
  logic [WIDTH-1:0] out;
  logic [2:0]       flags;

  modport master (output a, b, ops, input out, flags);
  modport slave  (input a, b, ops, output out, flags);
endinterface

// File: rtl/alu_debug_console_key_debounce.sv
// One pushbutton: 2-FF synchroniser, stability counter, and a press pulse on accepted falling edge.
module key_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic level,
  output logic press
);
  localparam int CNT_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);

  logic             s1_q, s1_d, s2_q, s2_d;
  logic [1:0]       vld_q, vld_d;
  logic             armed_q, armed_d;
  logic             lvl_q, lvl_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d    = key_raw;
    s2_d    = s1_q;
    vld_d   = {vld_q[0], 1'b1};
    // Presses only count once the synchronised key has been seen released after reset.
    armed_d = armed_q | (vld_q[1] & s2_q);
    lvl_d   = lvl_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (s2_q != lvl_q) begin
      if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        lvl_d   = s2_q;
        press_d = armed_q & ~s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      vld_q   <= '0;
      armed_q <= 1'b0;
      lvl_q   <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      vld_q   <= vld_d;
      armed_q <= armed_d;
      lvl_q   <= lvl_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = lvl_q;
  assign press = press_q;
endmodule

// File: rtl/alu_debug_console.sv
// Board console around one ALU: debounced keys drive chunked operand entry, execute, and result display.
module alu_debug_console
  import alu_console_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int CHUNK      = 16,
  parameter int NDIGITS    = 8,
  parameter int DEB_CYCLES = 500000
) (
  input  logic                 CLOCK_50,
  input  logic                 RST,
  input  logic [3:0]           KEY,
  input  logic [17:0]          SW,
  alu_if.master                alu,
  output logic [NDIGITS*7-1:0] HEX,
  output logic [17:0]          LEDR
);

  function automatic logic [NDIGITS*7-1:0] hex_reset_val();
    logic [NDIGITS*7-1:0] v;
    for (int i = 0; i < NDIGITS; i++)
      v[7*i +: 7] = (4*i < WIDTH) ? hex_to_seg(4'h0) : SEG_BLANK;
    return v;
  endfunction

  localparam logic [NDIGITS*7-1:0] HEX_RST = hex_reset_val();

  logic [3:0] key_lvl, key_press;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key [3:0] (
    .clk     (CLOCK_50),
    .rst     (RST),
    .key_raw (KEY),
    .level   (key_lvl),
    .press   (key_press)
  );

  logic unused_ok;
  assign unused_ok = ^{SW[17:CHUNK], key_lvl};

  logic ev_load, ev_next, ev_view, ev_clear;
  assign ev_load  = key_press[KEY_LOAD];
  assign ev_next  = key_press[KEY_NEXT];
  assign ev_view  = key_press[KEY_VIEW];
  assign ev_clear = key_press[KEY_CLEAR];

  console_state_t       state_q, state_d;
  view_t                view_q, view_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d, r_q, r_d;
  logic [3:0]           op_q, op_d;
  logic [2:0]           f_q, f_d, s_q, s_d;
  logic [NDIGITS*7-1:0] hex_q, hex_d;
  logic [17:0]          ledr_q, ledr_d;
  logic [WIDTH-1:0]     chunk_w, src;

  assign chunk_w = WIDTH'(SW[CHUNK-1:0]);

  always_comb begin
    state_d = state_q;
    view_d  = view_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    op_d    = op_q;
    f_d     = f_q;
    s_d     = s_q;
    if (ev_clear) begin
      state_d = LOAD_A;
      view_d  = VIEW_RES;
      a_d     = '0;
      b_d     = '0;
      r_d     = '0;
      op_d    = '0;
      f_d     = '0;
      s_d     = '0;
    end else begin
      case (state_q)
        LOAD_A: begin
          if (ev_load)      a_d = (a_q << CHUNK) | chunk_w;
          else if (ev_next) state_d = LOAD_B;
        end
        LOAD_B: begin
          if (ev_load) b_d = (b_q << CHUNK) | chunk_w;
          else if (ev_next) begin
            op_d    = SW[3:0];
            state_d = EXEC;
          end
        end
        EXEC: begin
          r_d     = alu.out;
          f_d     = alu.flags;
          s_d     = s_q | alu.flags;
          state_d = SHOW;
        end
        default: begin
          if (ev_next) state_d = LOAD_A;
          else if (ev_view) begin
            case (view_q)
              VIEW_RES: view_d = VIEW_A;
              VIEW_A:   view_d = VIEW_B;
              default:  view_d = VIEW_RES;
            endcase
          end
        end
      endcase
    end
  end

  always_comb begin
    case (state_q)
      LOAD_A:      src = a_q;
      LOAD_B,
      EXEC:        src = b_q;
      default: begin
        case (view_q)
          VIEW_A:  src = a_q;
          VIEW_B:  src = b_q;
          default: src = r_q;
        endcase
      end
    endcase
  end

  for (genvar i = 0; i < NDIGITS; i++) begin : g_digit
    if (4*i < WIDTH) begin : g_on
      assign hex_d[7*i +: 7] = hex_to_seg(src[4*i +: 4]);
    end else begin : g_off
      assign hex_d[7*i +: 7] = SEG_BLANK;
    end
  end

  assign ledr_d = {4'b0000, view_q, state_q, op_q, s_q, f_q};

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      state_q <= LOAD_A;
      view_q  <= VIEW_RES;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      op_q    <= '0;
      f_q     <= '0;
      s_q     <= '0;
      hex_q   <= HEX_RST;
      ledr_q  <= '0;
    end else begin
      state_q <= state_d;
      view_q  <= view_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      op_q    <= op_d;
      f_q     <= f_d;
      s_q     <= s_d;
      hex_q   <= hex_d;
      ledr_q  <= ledr_d;
    end
  end

  assign alu.a   = a_q;
  assign alu.b   = b_q;
  assign alu.ops = op_q;
  assign HEX     = hex_q;
  assign LEDR    = ledr_q;

endmodule
